// File: rtl/sap_core_param_if.sv
// Program-load and result bus of the SAP core. The core uses the slave side.
// The loader/observer uses the master side.
interface sap_core_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) ();
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              halted;
  logic [ADDR_W-1:0] pc;

  modport master (
    output prog_we, prog_addr, prog_data,
    input  out, out_valid, halted, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_data,
    output out, out_valid, halted, pc
  );
endinterface

// File: rtl/sap_core_param.sv
// Parametrised SAP-class core: six-phase sequencer with writable RAM, immediate load,
// conditional jumps on carry/zero and a registered output port.
module sap_core_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic            clk,
  input  logic            clr,
  sap_core_param_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJc  = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [2:0] {StT1, StT2, StT3, StT4, StT5, StT6, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] mem_q [Depth];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] imm;
  logic              is_sub;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W:0]   sum;

  assign ram_rdata = mem_q[mar_q];
  assign opcode    = ir_q[DATA_W-1 -: 4];
  assign operand   = ir_q[ADDR_W-1:0];
  assign imm       = {4'b0000, ir_q[DATA_W-5:0]};

  // Subtraction is ACC + ~B + 1, so the carry out doubles as "no borrow".
  assign is_sub = (opcode == OpSub);
  assign alu_b  = is_sub ? ~b_q : b_q;
  assign sum    = {1'b0, acc_q} + {1'b0, alu_b} + {{DATA_W{1'b0}}, is_sub};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    b_d         = b_q;
    c_d         = c_q;
    z_d         = z_q;
    out_d       = out_q;
    out_valid_d = 1'b0;

    unique case (state_q)
      StT1: begin
        mar_d   = pc_q;
        state_d = StT2;
      end
      StT2: begin
        pc_d    = pc_q + 1'b1;
        state_d = StT3;
      end
      StT3: begin
        ir_d    = ram_rdata;
        state_d = StT4;
      end
      StT4: begin
        state_d = StT5;
        case (opcode)
          OpLda, OpAdd, OpSub, OpSta: mar_d = operand;
          OpLdi: acc_d = imm;
          OpJmp: pc_d = operand;
          OpJc:  if (c_q) pc_d = operand;
          OpJz:  if (z_q) pc_d = operand;
          OpOut: begin
            out_d       = acc_q;
            out_valid_d = 1'b1;
          end
          OpHlt: state_d = StHalt;
          default: ;
        endcase
      end
      StT5: begin
        state_d = StT6;
        case (opcode)
          OpLda:        acc_d = ram_rdata;
          OpAdd, OpSub: b_d = ram_rdata;
          default: ;
        endcase
      end
      StT6: begin
        state_d = StT1;
        if (opcode == OpAdd || opcode == OpSub) begin
          acc_d = sum[DATA_W-1:0];
          c_d   = sum[DATA_W];
          z_d   = (sum[DATA_W-1:0] == '0);
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StT1;
    endcase
  end

  // The load port wins the RAM only while reset or halted; STA cannot coincide with either.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = mar_q;
    mem_wdata = acc_q;
    if (bus.prog_we && (clr || state_q == StHalt)) begin
      mem_we    = 1'b1;
      mem_waddr = bus.prog_addr;
      mem_wdata = bus.prog_data;
    end else if (!clr && state_q == StT5 && opcode == OpSta) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StT1;
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.halted    = (state_q == StHalt);
  assign bus.pc        = pc_q;

endmodule

// File: tb/tb_sap_core_param.sv
// Directed bench for sap_core_param: table of whole-program runs on the 8/4 core plus
// hand-written timing, lockout, wrap, mid-instruction reset and a 12/8 instance.
module tb_sap_core_param;

  logic clk = 1'b0;
  logic clr;
  logic clr2;

  always #5 clk = ~clk;

  sap_core_param_if #(.DATA_W(8), .ADDR_W(4)) bus ();
  sap_core_param_if #(.DATA_W(12), .ADDR_W(8)) bus2 ();

  sap_core_param #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  sap_core_param #(.DATA_W(12), .ADDR_W(8)) dut2 (
    .clk (clk),
    .clr (clr2),
    .bus (bus2.slave)
  );

  typedef struct packed {
    logic [15:0][7:0] prog;
    logic [7:0]       exp_out;
    logic [7:0]       exp_pulses;
    logic [2:0][7:0]  exp_p;
    logic [3:0]       exp_pc;
  } vec_t;

  vec_t        vecs  [5];
  string       names [5];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  pulse_q  [$];
  logic [11:0] pulse2_q [$];

  always @(negedge clk) begin
    if (bus.out_valid)  pulse_q.push_back(bus.out);
    if (bus2.out_valid) pulse2_q.push_back(bus2.out);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Writes words 0..n-1 under clr, then releases clr; the next edge is fetch T1.
  task automatic load_prog(input logic [15:0][7:0] prog, input int n);
    clr = 1'b1;
    for (int a = 0; a < n; a++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 4'(a);
      bus.prog_data = prog[a];
      step();
    end
    bus.prog_we = 1'b0;
    clr         = 1'b0;
    pulse_q.delete();
  endtask

  task automatic run_to_halt(input string name, input int max_cyc);
    int c = 0;
    while (!bus.halted && c < max_cyc) begin
      step();
      c++;
    end
    check({name, "_halt_reached"}, 32'(bus.halted), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t             v;
    logic [15:0][7:0] p;
    logic [11:0]      p2 [18];

    clr           = 1'b1;
    clr2          = 1'b1;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus2.prog_we  = 1'b0;
    bus2.prog_addr = '0;
    bus2.prog_data = '0;

    // Basic: LDA 9; ADD A; OUT; HLT -> 5+3
    v = '0;
    v.prog[0] = 8'h19; v.prog[1] = 8'h2A; v.prog[2] = 8'hE0; v.prog[3] = 8'hF0;
    v.prog[9] = 8'h05; v.prog[10] = 8'h03;
    v.exp_out = 8'h08; v.exp_pulses = 8'd1; v.exp_p[0] = 8'h08; v.exp_pc = 4'h4;
    vecs[0] = v; names[0] = "basic";

    // LDI 3; SUB E; OUT; JC 6; JZ 8; HLT | 6: JZ A; HLT | A: LDI C; OUT; HLT
    v = '0;
    v.prog[0] = 8'h53; v.prog[1] = 8'h3E; v.prog[2] = 8'hE0; v.prog[3] = 8'h76;
    v.prog[4] = 8'h88; v.prog[5] = 8'hF0; v.prog[6] = 8'h8A; v.prog[7] = 8'hF0;
    v.prog[8] = 8'hF0; v.prog[9] = 8'hF0; v.prog[10] = 8'h5C; v.prog[11] = 8'hE0;
    v.prog[12] = 8'hF0; v.prog[14] = 8'h05;
    v.exp_out = 8'hFE; v.exp_pulses = 8'd1; v.exp_p[0] = 8'hFE; v.exp_pc = 4'h6;
    vecs[1] = v; names[1] = "sub_borrow";

    v.prog[14] = 8'h03;
    v.exp_out = 8'h0C; v.exp_pulses = 8'd2; v.exp_p[0] = 8'h00; v.exp_p[1] = 8'h0C;
    v.exp_pc = 4'hD;
    vecs[2] = v; names[2] = "sub_equal";

    // Countdown: LDI 3; SUB F; OUT; JZ 5; JMP 1; HLT; F=1
    v = '0;
    v.prog[0] = 8'h53; v.prog[1] = 8'h3F; v.prog[2] = 8'hE0; v.prog[3] = 8'h85;
    v.prog[4] = 8'h61; v.prog[5] = 8'hF0; v.prog[15] = 8'h01;
    v.exp_out = 8'h00; v.exp_pulses = 8'd3;
    v.exp_p[0] = 8'h02; v.exp_p[1] = 8'h01; v.exp_p[2] = 8'h00; v.exp_pc = 4'h6;
    vecs[3] = v; names[3] = "countdown";

    // Store/reload: LDI 7; STA C; LDI 0; LDA C; OUT; HLT
    v = '0;
    v.prog[0] = 8'h57; v.prog[1] = 8'h4C; v.prog[2] = 8'h50; v.prog[3] = 8'h1C;
    v.prog[4] = 8'hE0; v.prog[5] = 8'hF0;
    v.exp_out = 8'h07; v.exp_pulses = 8'd1; v.exp_p[0] = 8'h07; v.exp_pc = 4'h6;
    vecs[4] = v; names[4] = "store_reload";

    // Reset state
    step();
    step();
    check("rst_out", 32'(bus.out), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_halted", 32'(bus.halted), 32'h0);
    check("rst_pc", 32'(bus.pc), 32'h0);

    for (int i = 0; i < 5; i++) begin
      load_prog(vecs[i].prog, 16);
      run_to_halt(names[i], 2000);
      step();
      step();
      check({names[i], "_out"}, 32'(bus.out), 32'(vecs[i].exp_out));
      check({names[i], "_pc"}, 32'(bus.pc), 32'(vecs[i].exp_pc));
      check({names[i], "_pulses"}, 32'(pulse_q.size()), 32'(vecs[i].exp_pulses));
      for (int k = 0; k < int'(vecs[i].exp_pulses) && k < pulse_q.size(); k++)
        check($sformatf("%s_pulse%0d", names[i], k), 32'(pulse_q[k]), 32'(vecs[i].exp_p[k]));
    end

    // RAM[C]=7 written by STA must survive clr; load only 0..2.
    p = '0;
    p[0] = 8'h1C; p[1] = 8'hE0; p[2] = 8'hF0;
    load_prog(p, 3);
    run_to_halt("persist", 200);
    check("persist_out", 32'(bus.out), 32'h07);

    // Exact timing of the basic program
    load_prog(vecs[0].prog, 16);
    for (int e = 1; e <= 15; e++) step();
    check("basic_e15_valid", 32'(bus.out_valid), 32'h0);
    step();
    check("basic_e16_out", 32'(bus.out), 32'h08);
    check("basic_e16_valid", 32'(bus.out_valid), 32'h1);
    step();
    check("basic_e17_valid", 32'(bus.out_valid), 32'h0);
    for (int e = 18; e <= 21; e++) step();
    check("basic_e21_halted", 32'(bus.halted), 32'h0);
    step();
    check("basic_e22_halted", 32'(bus.halted), 32'h1);
    check("basic_e22_pc", 32'(bus.pc), 32'h4);
    for (int e = 0; e < 8; e++) step();
    check("basic_hold_pc", 32'(bus.pc), 32'h4);
    check("basic_hold_halted", 32'(bus.halted), 32'h1);

    // Load-port lockout: LDA D; OUT; HLT with D=11
    p = '0;
    p[0] = 8'h1D; p[1] = 8'hE0; p[2] = 8'hF0; p[13] = 8'h11;
    load_prog(p, 14);
    step();
    step();
    bus.prog_we = 1'b1; bus.prog_addr = 4'hD; bus.prog_data = 8'h22;
    for (int e = 0; e < 4; e++) step();
    bus.prog_we = 1'b0;
    run_to_halt("lockout", 200);
    check("lockout_running_ignored", 32'(bus.out), 32'h11);
    bus.prog_we = 1'b1; bus.prog_addr = 4'hD; bus.prog_data = 8'h33;
    step();
    bus.prog_we = 1'b0;
    check("lockout_halt_stays", 32'(bus.halted), 32'h1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    run_to_halt("lockout_rerun", 200);
    check("lockout_halted_applied", 32'(bus.out), 32'h33);

    // PC wrap on an all-NOP program, with two undefined opcodes mixed in
    p = '0;
    p[5] = 8'h9F; p[6] = 8'hDF;
    load_prog(p, 16);
    for (int e = 1; e <= 92; e++) begin
      step();
      if (e == 2)  check("wrap_pc_e2", 32'(bus.pc), 32'h1);
      if (e == 86) check("wrap_pc_15", 32'(bus.pc), 32'hF);
      if (e == 92) check("wrap_pc_0", 32'(bus.pc), 32'h0);
    end
    check("wrap_no_halt", 32'(bus.halted), 32'h0);
    check("wrap_no_pulse", 32'(pulse_q.size()), 32'h0);

    // Reset at ADD T5: LDI 6; OUT; ADD A; OUT; HLT; A=3
    p = '0;
    p[0] = 8'h56; p[1] = 8'hE0; p[2] = 8'h2A; p[3] = 8'hE0; p[4] = 8'hF0; p[10] = 8'h03;
    load_prog(p, 11);
    for (int e = 1; e <= 16; e++) step();
    check("midrst_pre_out", 32'(bus.out), 32'h06);
    check("midrst_pre_pc", 32'(bus.pc), 32'h3);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("midrst_out", 32'(bus.out), 32'h0);
    check("midrst_valid", 32'(bus.out_valid), 32'h0);
    check("midrst_halted", 32'(bus.halted), 32'h0);
    check("midrst_pc", 32'(bus.pc), 32'h0);
    pulse_q.delete();
    run_to_halt("midrst_rerun", 200);
    check("midrst_rerun_out", 32'(bus.out), 32'h09);
    check("midrst_rerun_pulses", 32'(pulse_q.size()), 32'd2);

    // 12/8 core: 0x800+0x800 -> 0 with C=1, Z=1; JC 5 then JZ 7 reach LDI 5A; OUT
    for (int a = 0; a < 18; a++) p2[a] = 12'h000;
    p2[0] = 12'h110; p2[1] = 12'h211; p2[2] = 12'hE00; p2[3] = 12'h705;
    p2[4] = 12'hF00; p2[5] = 12'h807; p2[6] = 12'hF00; p2[7] = 12'h55A;
    p2[8] = 12'hE00; p2[9] = 12'hF00; p2[16] = 12'h800; p2[17] = 12'h800;
    for (int a = 0; a < 18; a++) begin
      bus2.prog_we   = 1'b1;
      bus2.prog_addr = 8'(a);
      bus2.prog_data = p2[a];
      step();
    end
    bus2.prog_we = 1'b0;
    clr2 = 1'b0;
    pulse2_q.delete();
    for (int c = 0; c < 500 && !bus2.halted; c++) step();
    check("w12_halt_reached", 32'(bus2.halted), 32'h1);
    check("w12_out", 32'(bus2.out), 32'h05A);
    check("w12_pc", 32'(bus2.pc), 32'h0A);
    check("w12_pulses", 32'(pulse2_q.size()), 32'd2);
    if (pulse2_q.size() > 0) check("w12_sum", 32'(pulse2_q[0]), 32'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_core_param.md
Name: sap_core_param

Overview:
- Parametrised next-generation SAP-class processor core: PC, MAR, IR, accumulator, B register, adder/subtractor, output register and control sequencer in one block.
- Generalised data and address widths.
- Adds writable RAM (store instruction), immediate load, and unconditional/conditional jumps on carry/zero flags.
- Program memory is filled through a load port while in reset or halted; results leave through a registered output port with a valid strobe.

Parameters:
DATA_W, 8, data/instruction word width; must satisfy DATA_W >= ADDR_W+4
ADDR_W, 4, address width; RAM depth = 2**ADDR_W words

Ports:
clk  input  1  system clock, all state updates on rising edge
clr  input  1  synchronous active-high reset
prog_we  input  1  program-load write enable
prog_addr  input  ADDR_W  program-load address
prog_data  input  DATA_W  program-load data
out  output  DATA_W  output register
out_valid  output  1  one-cycle pulse when OUT updates out
halted  output  1  high while core is in HALT
pc  output  ADDR_W  current program counter (debug)

Behaviour:
- Instruction word format:
  - opcode = bits [DATA_W-1:DATA_W-4].
  - operand = bits [ADDR_W-1:0].
  - immediate = bits [DATA_W-5:0], zero-extended to DATA_W.
- Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT. Any other opcode executes as NOP.
- RAM: asynchronous read at MAR; synchronous write. Contents are not affected by clr.
- Sequencer states: T1..T6 ring, plus HALT. Each non-HLT instruction takes exactly 6 cycles; after T6 the sequencer returns to T1.
  - T1: MAR <= PC.
  - T2: PC <= PC+1, mod 2**ADDR_W (wraps from all-ones to 0).
  - T3: IR <= RAM[MAR].
  - T4:
    - LDA/ADD/SUB/STA: MAR <= operand.
    - LDI: ACC <= immediate.
    - JMP: PC <= operand.
    - JC: PC <= operand if C=1.
    - JZ: PC <= operand if Z=1.
    - OUT: out <= ACC; out_valid high the following cycle only.
    - HLT: next state HALT.
  - T5:
    - LDA: ACC <= RAM[MAR].
    - ADD/SUB: B <= RAM[MAR].
    - STA: RAM[MAR] <= ACC.
  - T6: ADD/SUB only:
    - ACC <= ACC+B or ACC+~B+1, truncated to DATA_W.
    - C <= carry out of bit DATA_W-1; for SUB, C=1 means no borrow (ACC >= B unsigned).
    - Z <= (result == 0).
  - Cycles not listed for an opcode: no register change.
- Flags: C and Z change only at ADD/SUB T6; LDA, LDI, STA and jumps leave them unchanged.
- HALT: all registers hold; halted=1. The only exit is clr.
- Program load:
  - prog_we is honoured only when clr=1 or the core is in HALT.
  - When honoured: RAM[prog_addr] <= prog_data on that edge.
  - prog_we in any other state is ignored (no RAM change).
- Reset (clr=1 on an edge), from any state including mid-instruction or HALT:
  - PC, MAR, IR, ACC, B, C, Z, out <= 0.
  - out_valid <= 0, halted <= 0, state <= T1.
  - Takes priority over every other update except the program-load write.
- Reset values of all outputs: out=0, out_valid=0, halted=0, pc=0.
- Fetch after reset: the first rising edge with clr=0 performs T1 of the instruction at address 0.

Test Plan:
- Basic program, DATA_W=8, ADDR_W=4. Load during clr: RAM[0]=0x19, [1]=0x2A, [2]=0xE0, [3]=0xF0, [9]=0x05, [A]=0x03. Release clr.
  -> out=0x08 with out_valid high for exactly one cycle after the 16th edge.
  -> halted=1 after edge 22; pc stays 4 thereafter.
- Subtract/borrow: LDI 3; SUB from word =0x05; OUT; JC to 0x0; HLT.
  -> out=0xFE, C=0, Z=0.
  -> JC not taken; core halts.
  -> Repeat with word =0x03: out=0x00, C=1, Z=1.
- Store/reload: LDI 7; STA 0xC; LDI 0; LDA 0xC; OUT; HLT.
  -> out=0x07; RAM[0xC]=0x07 visible via a later halted-state check.
- Countdown loop with JZ/JMP: ACC from 3, SUB 1 each pass, OUT each pass.
  -> out_valid pulses carry 2, 1, 0.
  -> JZ exits loop; halted=1; total of exactly 3 out_valid pulses.
- PC wrap and load-port lockout:
  - All-NOP RAM: pc reads 15 then 0 on successive fetches.
  - prog_we pulsed while running -> RAM unchanged.
  - Same write while halted -> applied.
- Reset mid-operation, plus parametrised run:
  - clr asserted at ADD T5 -> all outputs 0 next cycle; re-run gives correct result.
  - DATA_W=12, ADDR_W=8: ADD of 0x800+0x800 -> ACC=0x000, C=1, Z=1.
